run_detect_moore: RTL and testbench

Parametrised Moore-style run-length detector, successor to the fixed 2-bit consecutive-ones counter. It counts consecutive occurrences of a selectable bit value up to a parametrised saturating width. It flags runs reaching a programmable threshold, in overlapping or non-overlapping mode, and keeps hit-event and longest-run statistics. It sits on a serial bit stream, e.g. sensor or line-code monitoring, and feeds status/debug logic.

---
 rtl/run_detect_moore.sv | 105 ++++++++++
 tb/tb_run_detect_moore.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/run_detect_moore.sv
// Moore run-length detector: counts consecutive bits equal to match_val, flags runs
// reaching THRESH (overlapping or restarting) and keeps hit-count / longest-run stats.
module run_detect_moore #(
  parameter int CNT_W   = 4,
  parameter int THRESH  = 3,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             match_val,
  output logic [CNT_W-1:0] run_len,
  output logic             hit,
  output logic [7:0]       hit_cnt,
  output logic [CNT_W-1:0] max_run,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    SAT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAXV     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] run_len_reg, run_len_next;
  logic [7:0]       hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0] max_run_reg, max_run_next;
  logic [CNT_W-1:0] n;
  logic             is_match;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_reg   <= IDLE;
      run_len_reg <= '0;
      hit_cnt_reg <= '0;
      max_run_reg <= '0;
    end else begin
      state_reg   <= state_next;
      run_len_reg <= run_len_next;
      hit_cnt_reg <= hit_cnt_next;
      max_run_reg <= max_run_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    run_len_next = run_len_reg;
    hit_cnt_next = hit_cnt_reg;
    max_run_next = max_run_reg;
    n            = '0;
    is_match     = (bit_in == match_val);

    if (clr) begin
      state_next   = IDLE;
      run_len_next = '0;
      hit_cnt_next = '0;
      max_run_next = '0;
    end else if (en) begin
      if (!is_match) begin
        state_next   = IDLE;
        run_len_next = '0;
      end else begin
        // Non-overlap mode restarts the run on the match after a hit.
        if (OVERLAP != 0)
          n = (run_len_reg == MAXV) ? MAXV : run_len_reg + ONE;
        else
          n = (state_reg == HIT) ? ONE : run_len_reg + ONE;

        run_len_next = n;

        if (n == '0)
          state_next = IDLE;
        else if (n < THRESH_V)
          state_next = RUN;
        else if ((n == MAXV) && (OVERLAP != 0))
          state_next = SAT;
        else
          state_next = HIT;

        // In overlap mode a run already sitting at THRESH (saturated there) is not a new event.
        if ((n == THRESH_V) && ((OVERLAP == 0) || (run_len_reg != THRESH_V)) &&
            (hit_cnt_reg != 8'hFF))
          hit_cnt_next = hit_cnt_reg + 8'd1;

        if (n > max_run_reg)
          max_run_next = n;
      end
    end
  end

  assign run_len = run_len_reg;
  assign hit_cnt = hit_cnt_reg;
  assign max_run = max_run_reg;
  assign state   = state_reg;
  assign hit     = (state_reg == HIT) || (state_reg == SAT);

endmodule

// File: tb/tb_run_detect_moore.sv
// Directed bench for run_detect_moore: one overlapping and one non-overlapping instance
// driven from the same stimulus, checked against hand-computed vectors.
module tb_run_detect_moore;

  logic       clk = 1'b0;
  logic       rst_p;
  logic       en, clr, bit_in, match_val;
  logic [3:0] ov_run, no_run, ov_max, no_max;
  logic [7:0] ov_cnt, no_cnt;
  logic [1:0] ov_st, no_st;
  logic       ov_hit, no_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_detect_moore #(.CNT_W(4), .THRESH(3), .OVERLAP(1)) dut_ov (
    .clk(clk), .rst_p(rst_p), .en(en), .clr(clr), .bit_in(bit_in), .match_val(match_val),
    .run_len(ov_run), .hit(ov_hit), .hit_cnt(ov_cnt), .max_run(ov_max), .state(ov_st)
  );

  run_detect_moore #(.CNT_W(4), .THRESH(3), .OVERLAP(0)) dut_no (
    .clk(clk), .rst_p(rst_p), .en(en), .clr(clr), .bit_in(bit_in), .match_val(match_val),
    .run_len(no_run), .hit(no_hit), .hit_cnt(no_cnt), .max_run(no_max), .state(no_st)
  );

  typedef struct {
    logic e, c, b, m;
    int   run, hit, cnt, mx, st;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ov(input string tag, input int run, input int h, input int cnt,
                        input int mx, input int st);
    chk({tag, " ov run_len"}, int'(ov_run), run);
    chk({tag, " ov hit"},     int'(ov_hit), h);
    chk({tag, " ov hit_cnt"}, int'(ov_cnt), cnt);
    chk({tag, " ov max_run"}, int'(ov_max), mx);
    chk({tag, " ov state"},   int'(ov_st),  st);
  endtask

  task automatic chk_no(input string tag, input int run, input int h, input int cnt,
                        input int mx, input int st);
    chk({tag, " no run_len"}, int'(no_run), run);
    chk({tag, " no hit"},     int'(no_hit), h);
    chk({tag, " no hit_cnt"}, int'(no_cnt), cnt);
    chk({tag, " no max_run"}, int'(no_max), mx);
    chk({tag, " no state"},   int'(no_st),  st);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic c, input logic b, input logic m);
    @(negedge clk);
    en = e; clr = c; bit_in = b; match_val = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en clr bit mv | run hit cnt max st  (overlap instance)
    tbl[0]  = '{1, 0, 1, 1, 1, 0, 0, 1, 1};
    tbl[1]  = '{1, 0, 1, 1, 2, 0, 0, 2, 1};
    tbl[2]  = '{1, 0, 1, 1, 3, 1, 1, 3, 2};
    tbl[3]  = '{1, 0, 1, 1, 4, 1, 1, 4, 2};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 1, 4, 0};
    tbl[5]  = '{1, 0, 1, 1, 1, 0, 1, 4, 1};
    tbl[6]  = '{1, 0, 1, 1, 2, 0, 1, 4, 1};
    tbl[7]  = '{0, 0, 0, 1, 2, 0, 1, 4, 1};
    tbl[8]  = '{0, 0, 1, 1, 2, 0, 1, 4, 1};
    tbl[9]  = '{0, 0, 0, 1, 2, 0, 1, 4, 1};
    tbl[10] = '{0, 0, 1, 1, 2, 0, 1, 4, 1};
    tbl[11] = '{0, 0, 0, 1, 2, 0, 1, 4, 1};
    tbl[12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 1, 1, 1, 0, 0, 1, 1};
    tbl[14] = '{1, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 1, 0, 0, 1, 1};
    tbl[16] = '{1, 0, 0, 0, 2, 0, 0, 2, 1};
    tbl[17] = '{1, 0, 0, 0, 3, 1, 1, 3, 2};

    en = 0; clr = 0; bit_in = 0; match_val = 1;
    rst_p = 1'b1;
    #2;
    chk_ov("reset", 0, 0, 0, 0, 0);
    chk_no("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_p = 1'b0;

    // Table: basic run, en hold, clr priority, match_val change, zero-matching
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].e, tbl[i].c, tbl[i].b, tbl[i].m);
      $display("vec %0d en=%0d clr=%0d bit=%0d mv=%0d -> run_len=%0d hit=%0d hit_cnt=%0d max_run=%0d state=%0d",
               i, tbl[i].e, tbl[i].c, tbl[i].b, tbl[i].m, ov_run, ov_hit, ov_cnt, ov_max, ov_st);
      chk_ov($sformatf("vec%0d", i), tbl[i].run, tbl[i].hit, tbl[i].cnt, tbl[i].mx, tbl[i].st);
    end

    // Asynchronous reset asserted mid-cycle, away from any edge
    #2 rst_p = 1'b1;
    #1;
    $display("async reset asserted -> run_len=%0d hit=%0d hit_cnt=%0d max_run=%0d state=%0d",
             ov_run, ov_hit, ov_cnt, ov_max, ov_st);
    chk_ov("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    en = 0;
    #2 rst_p = 1'b0;
    @(posedge clk);
    #1;
    chk_ov("rst_release", 0, 0, 0, 0, 0);

    // Non-overlap: seven 1s restart after each hit
    step(1, 1, 0, 1);
    chk_no("clr2", 0, 0, 0, 0, 0);
    begin
      int er[7] = '{1, 2, 3, 1, 2, 3, 1};
      int eh[7] = '{0, 0, 1, 0, 0, 1, 0};
      int ec[7] = '{0, 0, 1, 1, 1, 2, 2};
      int em[7] = '{1, 2, 3, 3, 3, 3, 3};
      int es[7] = '{1, 1, 2, 1, 1, 2, 1};
      for (int k = 0; k < 7; k++) begin
        step(1, 0, 1, 1);
        $display("nonovl bit %0d -> run_len=%0d hit=%0d hit_cnt=%0d max_run=%0d state=%0d",
                 k + 1, no_run, no_hit, no_cnt, no_max, no_st);
        chk_no($sformatf("nonovl%0d", k + 1), er[k], eh[k], ec[k], em[k], es[k]);
      end
    end

    // Overlap: twenty 1s saturate run_len at 15 in SAT
    step(1, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      int er, es;
      step(1, 0, 1, 1);
      er = (k < 15) ? k : 15;
      es = (k < 3) ? 1 : ((k < 15) ? 2 : 3);
      $display("sat bit %0d -> run_len=%0d hit=%0d hit_cnt=%0d max_run=%0d state=%0d",
               k, ov_run, ov_hit, ov_cnt, ov_max, ov_st);
      chk_ov($sformatf("sat%0d", k), er, (k >= 3) ? 1 : 0, (k >= 3) ? 1 : 0, er, es);
    end

    // 300 repetitions of 1,1,1,0: hit_cnt saturates at 255 in both modes
    step(1, 1, 0, 1);
    for (int r = 1; r <= 300; r++) begin
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      step(1, 0, 0, 1);
      if ((r % 50 == 0) || (r >= 254 && r <= 256))
        $display("rep %0d -> ov hit_cnt=%0d max_run=%0d | no hit_cnt=%0d max_run=%0d",
                 r, ov_cnt, ov_max, no_cnt, no_max);
      chk($sformatf("rep%0d ov hit_cnt", r), int'(ov_cnt), (r < 255) ? r : 255);
      chk($sformatf("rep%0d no hit_cnt", r), int'(no_cnt), (r < 255) ? r : 255);
      chk($sformatf("rep%0d ov max_run", r), int'(ov_max), 3);
      chk($sformatf("rep%0d ov state", r),   int'(ov_st),  0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
